// File: rtl/game_flow_if.sv
// Player/game-progress signal bundle between the maze top level and game_flow_fsm.
// The slave modport is the progress controller; the master modport is the game logic.
interface game_flow_if #(
  parameter int WORLD_W = 2,
  parameter int LEVEL_W = 3,
  parameter int LIVES_W = 4
);
  logic               start_btn;
  logic [1:0]         player_status;
  logic [2:0]         game_status;
  logic [WORLD_W-1:0] world;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic               level_load;

  modport master (
    output start_btn, player_status,
    input  game_status, world, level, lives, level_load
  );

  modport slave (
    input  start_btn, player_status,
    output game_status, world, level, lives, level_load
  );
endinterface

// File: rtl/game_flow_fsm.sv
// Game-progress controller: tracks world, level and lives from player pass/die reports,
// holds each transition screen for HOLD_CYCLES and strobes level_load on every return to play.
module game_flow_fsm #(
  parameter int NUM_WORLDS       = 4,
  parameter int LEVELS_PER_WORLD = 6,
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = 9,
  parameter int HOLD_CYCLES      = 100000000
) (
  input logic        clk,
  input logic        rst,
  game_flow_if.slave gameIf
);

  localparam int WORLD_W = (NUM_WORLDS > 1) ? $clog2(NUM_WORLDS) : 1;
  localparam int LEVEL_W = (LEVELS_PER_WORLD > 1) ? $clog2(LEVELS_PER_WORLD) : 1;
  localparam int LIVES_W = ($clog2(MAX_LIVES + 1) > 1) ? $clog2(MAX_LIVES + 1) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [WORLD_W-1:0] LAST_WORLD  = WORLD_W'(NUM_WORLDS - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(LEVELS_PER_WORLD - 1);
  localparam logic [LIVES_W-1:0] INIT_LIVES  = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_CEIL  = LIVES_W'(MAX_LIVES);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_LEVEL_INC = 3'd2,
    ST_WORLD_INC = 3'd3,
    ST_LIFE_LOST = 3'd4,
    ST_LOSE      = 3'd5,
    ST_WIN       = 3'd6
  } gameStateT;

  gameStateT          state_r;
  logic [WORLD_W-1:0] world_r;
  logic [LEVEL_W-1:0] level_r;
  logic [LIVES_W-1:0] lives_r;
  logic [HOLD_W-1:0]  holdCnt_r;
  logic               startPrev_r;
  logic               armed_r;
  logic               levelLoad_r;

  logic startEdge_s;
  logic statusIdle_s;
  logic statusPass_s;

  function automatic logic [LIVES_W-1:0] satIncLives(input logic [LIVES_W-1:0] cur);
    satIncLives = (cur >= LIVES_CEIL) ? LIVES_CEIL : cur + LIVES_W'(1);
  endfunction

  // Input decode: a start press is a rising edge; status 3 behaves like 0.
  assign startEdge_s  = gameIf.start_btn & ~startPrev_r;
  assign statusIdle_s = (gameIf.player_status == 2'd0) || (gameIf.player_status == 2'd3);
  assign statusPass_s = (gameIf.player_status == 2'd1);

  // Game-progress state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_START;
      world_r     <= '0;
      level_r     <= '0;
      lives_r     <= INIT_LIVES;
      holdCnt_r   <= '0;
      startPrev_r <= 1'b1;
      armed_r     <= 1'b0;
      levelLoad_r <= 1'b0;
    end else begin
      startPrev_r <= gameIf.start_btn;
      levelLoad_r <= 1'b0;
      case (state_r)
        ST_START: begin
          if (startEdge_s) begin
            state_r     <= ST_PLAYING;
            world_r     <= '0;
            level_r     <= '0;
            lives_r     <= INIT_LIVES;
            armed_r     <= 1'b0;
            levelLoad_r <= 1'b1;
          end
        end
        ST_PLAYING: begin
          // A pass/die report acts once per arming, so a stuck status yields one event.
          if (statusIdle_s) begin
            armed_r <= 1'b1;
          end else if (armed_r) begin
            armed_r   <= 1'b0;
            holdCnt_r <= HOLD_LOAD;
            if (statusPass_s) begin
              if (level_r < LAST_LEVEL) begin
                level_r <= level_r + LEVEL_W'(1);
                state_r <= ST_LEVEL_INC;
              end else if (world_r < LAST_WORLD) begin
                world_r <= world_r + WORLD_W'(1);
                level_r <= '0;
                lives_r <= satIncLives(lives_r);
                state_r <= ST_WORLD_INC;
              end else begin
                state_r <= ST_WIN;
              end
            end else begin
              if (lives_r > LIVES_W'(1)) begin
                lives_r <= lives_r - LIVES_W'(1);
                state_r <= ST_LIFE_LOST;
              end else begin
                lives_r <= '0;
                state_r <= ST_LOSE;
              end
            end
          end
        end
        ST_LEVEL_INC, ST_WORLD_INC, ST_LIFE_LOST: begin
          if (holdCnt_r == '0) begin
            state_r     <= ST_PLAYING;
            armed_r     <= 1'b0;
            levelLoad_r <= 1'b1;
          end else begin
            holdCnt_r <= holdCnt_r - HOLD_W'(1);
          end
        end
        ST_LOSE, ST_WIN: begin
          if (startEdge_s) begin
            state_r <= ST_START;
            world_r <= '0;
            level_r <= '0;
            lives_r <= INIT_LIVES;
          end
        end
        default: begin
          state_r <= ST_START;
        end
      endcase
    end
  end

  assign gameIf.game_status = state_r;
  assign gameIf.world       = world_r;
  assign gameIf.level       = level_r;
  assign gameIf.lives       = lives_r;
  assign gameIf.level_load  = levelLoad_r;

endmodule
